wave_ram_arbiter: RTL and testbench

//   Shares one single-port sample RAM between the audio capture path (writer) and the wave

---
 rtl/wave_arb_pkg.sv | 18 +
 rtl/wave_trigger_detect.sv | 42 ++++
 rtl/wave_ram_arbiter.sv | 120 ++++++++++++
 tb/tb_wave_ram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_arb_pkg.sv
// Shared types and helpers for the double-buffered wave RAM arbiter.
// Holds the capture FSM state encoding and the sample-to-display conversion.
package wave_arb_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        CAPTURING = 2'd1,
        FULL      = 2'd2
    } arb_state_e;

    // Flipping the sign bit maps signed two's complement onto unsigned offset binary.
    function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic signed [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/wave_trigger_detect.sv
// Rising zero-crossing trigger with a forced-capture timeout.
// Emits a one-cycle start_capture pulse while the arbiter is armed.
module wave_trigger_detect
    import wave_arb_pkg::*;
#(
    parameter int TRIG_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_armed,
    input  logic i_wr_valid,
    input  logic i_sample_msb,
    output logic o_start_capture
);

    localparam int CNT_W = $clog2(TRIG_TIMEOUT + 1);

    logic             r_prev_neg;
    logic [CNT_W-1:0] r_timeout_cnt;
    logic             w_trigger;
    logic             w_timeout;

    assign w_trigger       = i_armed & i_wr_valid & r_prev_neg & ~i_sample_msb;
    assign w_timeout       = i_armed & i_wr_valid & (r_timeout_cnt == CNT_W'(TRIG_TIMEOUT - 1));
    assign o_start_capture = w_trigger | w_timeout;

    // prev_neg tracks every sample; the timeout only counts samples seen while armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_neg    <= 1'b0;
            r_timeout_cnt <= '0;
        end else begin
            if (i_wr_valid)
                r_prev_neg <= i_sample_msb;
            if (!i_armed || o_start_capture)
                r_timeout_cnt <= '0;
            else if (i_wr_valid)
                r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wave_ram_arbiter.sv
// Single-port sample RAM shared between audio capture (writer) and wave display (reader).
// Captures a triggered sweep into the back half and swaps halves on vsync once full.
module wave_ram_arbiter
    import wave_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int TRIG_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic signed [15:0]       wr_data,
    input  logic                     rd_req,
    input  logic        [ADDR_W-1:0] rd_addr,
    output logic        [DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     vsync,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic        [ADDR_W:0]   ram_addr,
    output logic        [DATA_W-1:0] ram_wdata,
    input  logic        [DATA_W-1:0] ram_rdata,
    output logic                     front_half,
    output logic        [7:0]        drop_count
);

    arb_state_e          r_state;
    logic                r_front_half;
    logic                r_pend_vld;
    logic [DATA_W-1:0]   r_pend_data;
    logic [ADDR_W-1:0]   r_windex;
    logic [7:0]          r_drop_cnt;
    logic                r_vsync_q;
    logic                r_rd_vld_p1;

    logic [SAMPLE_W-1:0] w_ob;
    logic [DATA_W-1:0]   w_sample;
    logic                w_armed;
    logic                w_start;
    logic                w_rd_issue;
    logic                w_wr_issue;
    logic                w_last_wr;
    logic                w_vsync_rise;
    logic                w_load;
    logic                w_drop;

    wave_trigger_detect #(
        .TRIG_TIMEOUT(TRIG_TIMEOUT)
    ) u_trig (
        .clk            (clk),
        .reset          (reset),
        .i_armed        (w_armed),
        .i_wr_valid     (wr_valid),
        .i_sample_msb   (wr_data[15]),
        .o_start_capture(w_start)
    );

    assign w_ob         = to_offset_binary(wr_data);
    assign w_sample     = w_ob[SAMPLE_W-1 -: DATA_W];
    assign w_armed      = (r_state == ARMED);
    assign w_vsync_rise = vsync & ~r_vsync_q;

    // Reader has absolute priority; the one-deep pending slot waits out any read burst.
    assign w_rd_issue = rd_req & ~reset;
    assign w_wr_issue = r_pend_vld & ~rd_req & ~reset;
    assign w_last_wr  = w_wr_issue & (r_windex == '1);

    // A sample coinciding with the final sweep write is ignored, as FULL would ignore it.
    assign w_load = wr_valid & ((w_armed & w_start) |
                                ((r_state == CAPTURING) & ~w_last_wr));
    assign w_drop = w_load & r_pend_vld & ~w_wr_issue;

    assign ram_en     = w_rd_issue | w_wr_issue;
    assign ram_we     = w_wr_issue;
    assign ram_addr   = w_rd_issue ? {r_front_half, rd_addr} : {~r_front_half, r_windex};
    assign ram_wdata  = r_pend_data;
    assign rd_data    = ram_rdata;
    assign rd_valid   = r_rd_vld_p1;
    assign front_half = r_front_half;
    assign drop_count = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARMED;
            r_front_half <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_windex     <= '0;
            r_drop_cnt   <= '0;
            r_vsync_q    <= 1'b0;
            r_rd_vld_p1  <= 1'b0;
        end else begin
            r_vsync_q   <= vsync;
            r_rd_vld_p1 <= rd_req;
            r_pend_vld  <= w_load | (r_pend_vld & ~w_wr_issue);
            if (w_wr_issue)
                r_windex <= r_windex + ADDR_W'(1);
            if (w_drop && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
            case (r_state)
                ARMED:     if (w_start) r_state <= CAPTURING;
                CAPTURING: if (w_last_wr) r_state <= FULL;
                FULL: begin
                    if (w_vsync_rise) begin
                        r_state      <= ARMED;
                        r_front_half <= ~r_front_half;
                    end
                end
                default:   r_state <= ARMED;
            endcase
        end
    end

    // Sample data path carries no reset; only the valid flag qualifies it.
    always_ff @(posedge clk) begin
        if (w_load)
            r_pend_data <= w_sample;
    end

endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Self-checking bench for wave_ram_arbiter with a behavioural RAM and sweep model.
module tb_wave_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        vsync = 1'b0;
    logic        ram_en;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic        front_half;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    typedef struct { int a; int d; } wr_t;
    wr_t  wlog[$];
    logic [7:0] mem [0:511];
    int   expd [0:255];

    wave_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .TRIG_TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .vsync(vsync), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .front_half(front_half),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: one-cycle read latency, every write logged.
    always @(negedge clk) begin
        if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wlog.push_back('{int'(ram_addr), int'(ram_wdata)});
        end
        if (ram_en && !ram_we)
            ram_rdata <= mem[ram_addr];
    end

    function automatic int ob(input logic [15:0] s);
        return ((int'(s) >> 8) ^ 32'h80) & 32'hFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s);
        wr_data  = s;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (front_half !== 1'b0) begin bad++; $display("FAIL reset_front act=%0b exp=0", front_half); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop act=%0d exp=0", drop_count); end
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en act=%0b exp=0", ram_en); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we act=%0b exp=0", ram_we); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid act=%0b exp=0", rd_valid); end
    endtask

    task automatic test_capture();
        logic [15:0] s;
        wlog.delete();
        send(16'hFFFB);
        total++; if (wlog.size() != 0) begin bad++; $display("FAIL cap_no_pretrig act=%0d exp=0", wlog.size()); end
        send(16'h0003);
        expd[0] = ob(16'h0003);
        for (int i = 1; i < 256; i++) begin
            s = 16'($urandom);
            expd[i] = ob(s);
            send(s);
        end
        total++; if (wlog.size() != 256) begin bad++; $display("FAIL cap_count act=%0d exp=256", wlog.size()); end
        if (wlog.size() >= 1) begin
            total++; if (wlog[0].d != 8'h80) begin bad++; $display("FAIL cap_first_data act=%0h exp=80", wlog[0].d); end
        end
        for (int i = 0; i < 256 && i < wlog.size(); i++) begin
            total++;
            if (wlog[i].a != 256 + i || wlog[i].d != expd[i]) begin
                bad++;
                $display("FAIL cap_write[%0d] act=%0h:%0h exp=%0h:%0h", i, wlog[i].a, wlog[i].d, 256 + i, expd[i]);
            end
        end
        send(16'h8001);
        send(16'h0100);
        total++; if (wlog.size() != 256) begin bad++; $display("FAIL full_ignores act=%0d exp=256", wlog.size()); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL full_no_drop act=%0d exp=0", drop_count); end
        total++; if (front_half !== 1'b0) begin bad++; $display("FAIL full_front act=%0b exp=0", front_half); end
    endtask

    task automatic test_swap();
        int r;
        vsync = 1'b1;
        #1;
        total++; if (front_half !== 1'b0) begin bad++; $display("FAIL swap_before act=%0b exp=0", front_half); end
        step();
        total++; if (front_half !== 1'b1) begin bad++; $display("FAIL swap_after act=%0b exp=1", front_half); end
        vsync = 1'b0;
        rd_req = 1'b1;
        rd_addr = 8'd0;
        #1;
        total++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin bad++; $display("FAIL rd_strobe act=%0b%0b exp=10", ram_en, ram_we); end
        total++; if (ram_addr !== 9'h100) begin bad++; $display("FAIL rd_addr act=%0h exp=100", ram_addr); end
        step();
        rd_req = 1'b0;
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_valid act=%0b exp=1", rd_valid); end
        total++; if (rd_data !== 8'h80) begin bad++; $display("FAIL rd_data0 act=%0h exp=80", rd_data); end
        step();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_drop act=%0b exp=0", rd_valid); end
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 255);
            rd_req = 1'b1;
            rd_addr = 8'(r);
            step();
            rd_req = 1'b0;
            total++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(expd[r])) begin
                bad++;
                $display("FAIL rd_rand[%0d] act=%0b:%0h exp=1:%0h", r, rd_valid, rd_data, expd[r]);
            end
        end
    endtask

    task automatic test_drop();
        logic [15:0] a, b;
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
        total++; if (front_half !== 1'b1) begin bad++; $display("FAIL vsync_armed act=%0b exp=1", front_half); end
        wlog.delete();
        send(16'h8000);
        send(16'h1234);
        total++; if (wlog.size() != 1 || wlog[0].a != 0 || wlog[0].d != ob(16'h1234)) begin
            bad++; $display("FAIL trig_write act_n=%0d exp_n=1 exp=0:%0h", wlog.size(), ob(16'h1234));
        end
        a = 16'($urandom);
        b = 16'($urandom);
        rd_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            wr_valid = (c == 2 || c == 5);
            wr_data  = (c == 2) ? a : b;
            step();
        end
        rd_req = 1'b0;
        wr_valid = 1'b0;
        #1;
        total++; if (wlog.size() != 1) begin bad++; $display("FAIL burst_blocks act=%0d exp=1", wlog.size()); end
        total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL drop_count act=%0d exp=1", drop_count); end
        total++; if (ram_we !== 1'b1 || ram_addr !== 9'd1 || ram_wdata !== 8'(ob(b))) begin
            bad++; $display("FAIL post_burst_wr act=%0b:%0h:%0h exp=1:1:%0h", ram_we, ram_addr, ram_wdata, ob(b));
        end
        step();
    endtask

    task automatic test_collide();
        logic [15:0] c, d;
        int r;
        c = 16'($urandom);
        d = 16'($urandom);
        r = $urandom_range(0, 255);
        wr_data = c;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        rd_req = 1'b1;
        rd_addr = 8'(r);
        #1;
        total++; if (ram_we !== 1'b0 || ram_addr !== {1'b1, 8'(r)}) begin
            bad++; $display("FAIL collide_read act=%0b:%0h exp=0:%0h", ram_we, ram_addr, 256 + r);
        end
        step();
        rd_req = 1'b0;
        wr_data = d;
        wr_valid = 1'b1;
        #1;
        total++; if (ram_we !== 1'b1 || ram_addr !== 9'd2 || ram_wdata !== 8'(ob(c))) begin
            bad++; $display("FAIL collide_write act=%0b:%0h:%0h exp=1:2:%0h", ram_we, ram_addr, ram_wdata, ob(c));
        end
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'(expd[r])) begin
            bad++; $display("FAIL collide_rdata act=%0b:%0h exp=1:%0h", rd_valid, rd_data, expd[r]);
        end
        step();
        wr_valid = 1'b0;
        #1;
        total++; if (ram_we !== 1'b1 || ram_addr !== 9'd3 || ram_wdata !== 8'(ob(d))) begin
            bad++; $display("FAIL reload_write act=%0b:%0h:%0h exp=1:3:%0h", ram_we, ram_addr, ram_wdata, ob(d));
        end
        total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL reload_no_drop act=%0d exp=1", drop_count); end
        step();
    endtask

    task automatic test_timeout_and_reset();
        logic [15:0] s;
        do_reset();
        step();
        wlog.delete();
        for (int i = 0; i < 1024; i++) begin
            s = 16'($urandom_range(0, 32767));
            if (i == 1023) begin
                total++; if (wlog.size() != 0) begin bad++; $display("FAIL timeout_early act=%0d exp=0", wlog.size()); end
            end
            send(s);
        end
        total++; if (wlog.size() != 1 || wlog[0].a != 256 || wlog[0].d != ob(s)) begin
            bad++; $display("FAIL timeout_write act_n=%0d exp_n=1 exp=100:%0h", wlog.size(), ob(s));
        end
        for (int i = 1; i < 100; i++) send(16'($urandom));
        total++; if (wlog.size() != 100) begin bad++; $display("FAIL pre_reset_count act=%0d exp=100", wlog.size()); end
        reset = 1'b1;
        wr_valid = 1'b1;
        wr_data = 16'h8000;
        step();
        reset = 1'b0;
        wr_valid = 1'b0;
        #1;
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL midrst_ram_en act=%0b exp=0", ram_en); end
        total++; if (front_half !== 1'b0) begin bad++; $display("FAIL midrst_front act=%0b exp=0", front_half); end
        step();
        send(16'h0200);
        total++; if (wlog.size() != 100) begin bad++; $display("FAIL midrst_armed act=%0d exp=100", wlog.size()); end
        send(16'hC000);
        send(16'h0345);
        total++; if (wlog.size() != 101 || wlog[100].a != 256 || wlog[100].d != ob(16'h0345)) begin
            bad++; $display("FAIL midrst_windex act_n=%0d exp_n=101 exp=100:%0h", wlog.size(), ob(16'h0345));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream[$];
        logic [15:0] s;
        int seq, p, exp_drop, budget;
        bit lost;
        do_reset();
        step();
        wlog.delete();
        send(16'h8000);
        seq = 16;
        s = {8'(seq), 8'($urandom)};
        stream.push_back(s);
        wr_data = s;
        wr_valid = 1'b1;
        step();
        budget = 0;
        while (wlog.size() < 256 && budget < 6000) begin
            rd_req = ($urandom_range(0, 1) == 0);
            rd_addr = 8'($urandom);
            wr_valid = ($urandom_range(0, 2) == 0);
            if (wr_valid) begin
                seq++;
                s = {8'(seq), 8'($urandom)};
                wr_data = s;
                stream.push_back(s);
            end
            step();
            budget++;
        end
        rd_req = 1'b0;
        wr_valid = 1'b0;
        step();
        total++; if (wlog.size() != 256) begin bad++; $display("FAIL b2b_sweep_len act=%0d exp=256", wlog.size()); end
        p = -1;
        lost = 1'b0;
        for (int i = 0; i < 256 && i < wlog.size() && !lost; i++) begin
            p++;
            while (p < stream.size() && ob(stream[p]) != wlog[i].d) p++;
            total++;
            if (p >= stream.size() || wlog[i].a != 256 + i) begin
                bad++;
                lost = 1'b1;
                $display("FAIL b2b_write[%0d] act=%0h:%0h exp_addr=%0h in_order=%0b", i, wlog[i].a, wlog[i].d, 256 + i, p < stream.size());
            end
        end
        exp_drop = (p + 1 - 256 > 255) ? 255 : p + 1 - 256;
        total++; if (!lost && int'(drop_count) != exp_drop) begin
            bad++; $display("FAIL b2b_drops act=%0d exp=%0d", drop_count, exp_drop);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        test_reset();
        test_capture();
        test_swap();
        test_drop();
        test_collide();
        test_timeout_and_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
